// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared codes for the multicycle core's sequencing stage: the instruction
// phase encoding and the default reset/halt addresses.
// No ports. No configuration macros.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

  // FETCH/EXEC1/EXEC2 encodings are fixed by the control decoder; HALTED is
  // the remaining code point.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_delay_slot.sv
// -----------------------------------------------------------------------------
// pc_delay_slot
// Branch-delay-slot tracker. Remembers a taken branch target until the
// delay-slot instruction commits, and computes the PC value to load at the
// current commit.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   commit_i           commit strobe (EXEC2, write enable, no stall)
//   branch_taken_i     committing instruction redirects control flow
//   branch_target_i    redirect target (already masked by the top if needed)
//   pc_i               current PC
//   next_pc_o          PC value to load on this commit
//   pending_next_o     delay_pending value after this commit
// No configuration macros.
// -----------------------------------------------------------------------------
module pc_delay_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        pending_next_o
);

  logic        pending_q, pending_d;
  logic [31:0] target_q, target_d;

  // Next-PC selection and delay-slot bookkeeping; a pending target always
  // wins over a branch sitting in the delay slot.
  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    if (pending_q) begin
      next_pc_o      = target_q;
      pending_next_o = 1'b0;
    end else begin
      next_pc_o      = pc_i + 32'd4;
      pending_next_o = branch_taken_i;
    end
    if (commit_i) begin
      pending_d = pending_next_o;
      if (!pending_q && branch_taken_i) begin
        target_d = branch_target_i;
      end else begin
        target_d = target_q;
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // Delay-slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      target_q  <= 32'd0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Three-phase instruction FSM (FETCH -> EXEC1 -> EXEC2) and program counter
// with branch-delay-slot handling and halt detection.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   stall_i            memory waitrequest; freezes state and PC
//   pc_write_en_i      commit strobe, honoured only in EXEC2
//   branch_taken_i     EXEC2 instruction redirects control flow
//   branch_target_i    redirect target
//   state_o            current phase
//   pc_o               address of the current instruction
//   link_addr_o        pc_o + 8 (combinational)
//   active_o           high until the core halts
//   fault_o            misaligned-target fault
// Configuration macro: PC_ALIGN_CHECK_EN
//   defined   - a commit loading a misaligned PC halts with fault_o=1 and
//               leaves the PC unchanged
//   undefined - target bits [1:0] are masked on capture, fault_o is 0
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        pc_write_en_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output state_t      state_o,
  output logic [31:0] pc_o,
  output logic [31:0] link_addr_o,
  output logic        active_o,
  output logic        fault_o
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        active_q, active_d;
  logic        fault_q, fault_d;

  logic        commit_s;
  logic [31:0] target_capture_s;
  logic [31:0] next_pc_s;
  logic        pending_next_s;

  assign commit_s = (state_q == EXEC2) && pc_write_en_i && !stall_i;

`ifdef PC_ALIGN_CHECK_EN
  assign target_capture_s = branch_target_i;
`else
  assign target_capture_s = {branch_target_i[31:2], 2'b00};
`endif

  pc_delay_slot u_delay_slot (
    .clk            (clk),
    .reset          (reset),
    .commit_i       (commit_s),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(target_capture_s),
    .pc_i           (pc_q),
    .next_pc_o      (next_pc_s),
    .pending_next_o (pending_next_s)
  );

  // Next-state, PC, halt and fault logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    active_d = active_q;
    fault_d  = fault_q;
    case (state_q)
      FETCH: begin
        if (!stall_i) state_d = EXEC1;
        else          state_d = FETCH;
      end
      EXEC1: begin
        if (!stall_i) state_d = EXEC2;
        else          state_d = EXEC1;
      end
      EXEC2: begin
        if (stall_i) begin
          state_d = EXEC2;
        end else if (pc_write_en_i) begin
`ifdef PC_ALIGN_CHECK_EN
          if (next_pc_s[1:0] != 2'b00) begin
            state_d  = HALTED;
            active_d = 1'b0;
            fault_d  = 1'b1;
          end else
`endif
          begin
            pc_d = next_pc_s;
            // Halt only once no delay-slot redirect is still outstanding.
            if ((next_pc_s == HALT_ADDR) && !pending_next_s) begin
              state_d  = HALTED;
              active_d = 1'b0;
            end else begin
              state_d = FETCH;
            end
          end
        end else begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_VECTOR;
      active_q <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      active_q <= active_d;
      fault_q  <= fault_d;
    end
  end

  assign state_o     = state_q;
  assign pc_o        = pc_q;
  assign link_addr_o = pc_q + 32'd8;
  assign active_o    = active_q;
  assign fault_o     = fault_q;

endmodule
